// File: rtl/bfifo_fwft.sv
// First-word-fall-through FIFO on a synchronous-read RAM, with a valid-qualified head register and optional sticky error flags (FIFO_ERRFLAG_EN).
// Latency: a word enqueued into an empty FIFO is on dot one cycle after its write edge; enq+deq streams at one word per cycle.
// Backpressure: enq is ignored while full, even if deq is accepted that cycle; deq is ignored while !dot_vld.
module bfifo_fwft #(
    parameter int FIFO_SIZE  = 4,
    parameter int FIFO_WIDTH = 32,
    parameter int AFULL_TH   = (1 << FIFO_SIZE) - 2,
    parameter int AEMP_TH    = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  enq,
    input  logic [FIFO_WIDTH-1:0] din,
    input  logic                  deq,
    output logic [FIFO_WIDTH-1:0] dot,
    output logic                  dot_vld,
    output logic                  emp,
    output logic                  full,
    output logic                  afull,
    output logic                  aemp,
    output logic [FIFO_SIZE:0]    cnt,
    output logic                  ovf,
    output logic                  udf
);

    localparam int                 DEPTH   = 1 << FIFO_SIZE;
    localparam logic [FIFO_SIZE:0] CNT_MAX = (FIFO_SIZE+1)'(DEPTH);
    localparam logic [FIFO_SIZE:0] AFULL_V = (FIFO_SIZE+1)'(AFULL_TH);
    localparam logic [FIFO_SIZE:0] AEMP_V  = (FIFO_SIZE+1)'(AEMP_TH);
    localparam logic [FIFO_SIZE:0] CNT_ONE = (FIFO_SIZE+1)'(1);
    localparam logic [FIFO_SIZE-1:0] PTR_ONE = FIFO_SIZE'(1);

    logic [FIFO_WIDTH-1:0] mem [DEPTH];
    logic [FIFO_SIZE-1:0]  head;
    logic [FIFO_SIZE-1:0]  tail;
    logic [FIFO_SIZE:0]    ram_cnt;
    logic                  enq_acc;
    logic                  deq_acc;
    logic                  prefetch;

    // Accept qualifiers; prefetch refills the head register whenever it is empty or being consumed.
    // ram_cnt is the pre-edge count, so a word written this cycle is never read in the same cycle.
    always_comb begin
        enq_acc  = enq && !full;
        deq_acc  = deq && dot_vld;
        prefetch = (ram_cnt != '0) && (!dot_vld || deq_acc);
    end

    // RAM write port; contents are deliberately left unreset so the array maps onto block RAM.
    always_ff @(posedge CLK) begin
        if (enq_acc) begin
            mem[tail] <= din;
        end
    end

    // Pointers, occupancy counters and the registered head word (the RAM read port).
    always_ff @(posedge CLK) begin
        if (RST) begin
            head    <= '0;
            tail    <= '0;
            ram_cnt <= '0;
            cnt     <= '0;
            dot_vld <= 1'b0;
            dot     <= '0;
        end else begin
            if (enq_acc) begin
                tail <= tail + PTR_ONE;
            end
            if (prefetch) begin
                dot     <= mem[head];
                head    <= head + PTR_ONE;
                dot_vld <= 1'b1;
            end else if (deq_acc) begin
                dot_vld <= 1'b0;
            end
            case ({enq_acc, prefetch})
                2'b10:   ram_cnt <= ram_cnt + CNT_ONE;
                2'b01:   ram_cnt <= ram_cnt - CNT_ONE;
                default: ram_cnt <= ram_cnt;
            endcase
            case ({enq_acc, deq_acc})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // Status flags decoded from the registered total count.
    always_comb begin
        emp   = (cnt == '0);
        full  = (cnt == CNT_MAX);
        afull = (cnt >= AFULL_V);
        aemp  = (cnt <= AEMP_V);
    end

`ifdef FIFO_ERRFLAG_EN
    // Sticky protocol-error flags: set on a refused request, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (enq && full) begin
                ovf <= 1'b1;
            end
            if (deq && !dot_vld) begin
                udf <= 1'b1;
            end
        end
    end
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

endmodule
